seg7_display: RTL and testbench
===============================

# seg7_display

Multi-digit seven-segment display driver that generalises our single-digit hex decoder to `NUM_DIGITS` parallel displays. It adds registered loading with a valid/ready handshake and hex or decimal display modes. Decimal mode uses an iterative binary-to-BCD converter. It also supports leading-zero blanking and per-digit blinking. It sits between the CPU's memory-mapped display register and the board's HEX outputs.

## Interface
- `NUM_DIGITS`, 6: number of displays driven.
- `BIN_W`, 16: binary width converted in decimal mode. Constraint: 2^BIN_W − 1 < 10^NUM_DIGITS.
- `BLINK_HALF_PERIOD`, 25_000_000: clock cycles per blink half-period (0.5 s at 50 MHz).
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: a new value is offered.
- `load_ready` out 1: the block can accept a load.
- `value` in 4*NUM_DIGITS: the value to display. In hex mode, nibble i goes to digit i. In decimal mode, only `value[BIN_W-1:0]` is used.
- `dec_mode` in 1: 1 selects decimal, 0 selects hex. Sampled at load.
- `blank_lz` in 1: 1 blanks leading zeros. Sampled at load.
- `blink_mask` in NUM_DIGITS: 1 blinks digit i. Used live, not sampled.
- `seg` out 7*NUM_DIGITS: active-low segments. Digit i occupies `[7i+6:7i]` with bit order {g,f,e,d,c,b,a}. Digit 0 is the least significant.

## Operation
- States are IDLE and CONVERT. `load_ready` = (state == IDLE).
- A load is accepted when `load_valid && load_ready`. The accept cycle samples `value`, `dec_mode` and `blank_lz`.
- Hex mode: stay in IDLE. The digit register takes `value` nibbles directly.
- Decimal mode: go to CONVERT. Run double-dabble for BIN_W iterations, one per cycle: add 3 to each BCD nibble ≥ 5, then shift left one bit. After the last iteration, write the BCD result to the digit register and return to IDLE.
- `load_valid` during CONVERT is ignored; no queueing.
- Leading-zero blanking, when enabled: blank every digit above the highest nonzero digit. Digit 0 is never blanked by this rule, so value 0 shows "0".
- Blink: a free-running counter counts 0..BLINK_HALF_PERIOD−1 and then wraps. On each wrap, `blink_phase` toggles. While `blink_phase` = 1, digits with `blink_mask[i]` = 1 are blanked.
- A blank digit drives 7'b1111111.
- Segment codes for 0–F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Reset values:
  - state IDLE, `load_ready` = 1;
  - digit register all zero, with a `valid_disp` flag = 0 that blanks all digits;
  - blink counter 0, `blink_phase` 0;
  - all `seg` = 1 (all segments off).

## Timing
- `seg` is registered.
- Hex load accepted in cycle t: `seg` shows the new value from cycle t+1.
- Decimal load accepted in cycle t:
  - `load_ready` is low from t+1 through t+BIN_W;
  - `seg` updates at t+BIN_W+1;
  - `load_ready` is high again at t+BIN_W+1.
- During CONVERT, `seg` keeps the previous value.
- A `blink_mask` change, or a `blink_phase` toggle at cycle t, shows on `seg` at t+1.
- Reset asserted mid-conversion: the next cycle is in IDLE with all digits blank and no result written.
- Reset has priority over a simultaneous load.

## Structure
- Package `seg7_pkg` holds:
  - `SEG_BLANK` = 7'h7F;
  - the segment lookup function `hex_to_seg(logic [3:0])`;
  - the `state_t` enum {IDLE, CONVERT}.
- Sub-module `bin2bcd_seq` is the iterative double-dabble converter, parametrised by BIN_W and NUM_DIGITS. Its interface is start/busy/done plus the bcd output.
- The top level holds the handshake, digit register, blanking, blink counter and output register.

## Test plan
- Reset → all `seg` = 7'h7F and `load_ready` = 1. Release reset and hold `load_valid` = 0 → `seg` stays blank.
- Hex load `value` = 24'h00A3F0 with `blank_lz` = 1 → at t+1:
  - digits 5, 4 = 1111111;
  - digit 3 = 0001000;
  - digit 2 = 0110000;
  - digit 1 = 0001110;
  - digit 0 = 1000000.
- Decimal load `value` = 16'd1234 with `blank_lz` = 1 → `load_ready` low for 16 cycles. At t+17:
  - digits 5, 4 blank;
  - digit 3 = 1111001;
  - digit 2 = 0100100;
  - digit 1 = 0110000;
  - digit 0 = 0011001.
- Decimal load 16'd65535, then a second `load_valid` pulse during CONVERT → the second load is ignored. Result digits are 0,6,5,5,3,5 (digit 5 down to digit 0), with digit 5 shown as 1000000 when `blank_lz` = 0.
- With `BLINK_HALF_PERIOD` = 4 and `blink_mask` = 6'b000001 → digit 0 toggles between its code and blank every 4 cycles; other digits are steady.
- Assert `rst` 5 cycles into a decimal conversion → the next cycle is IDLE with all digits blank. A subsequent hex load of 0 with `blank_lz` = 1 shows digit 0 = 1000000 and the others blank.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, state type and segment lookup for seg7_display
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {IDLE, CONVERT} state_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, one iteration per cycle
module bin2bcd_seq #(
  parameter int BIN_W      = 16,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int ACC_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  function automatic logic [ACC_W-1:0] dabble(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] t;
    t = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[BIN_W+4*i +: 4] >= 4'd5) t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  // The first iteration runs on the start edge so the result is complete
  // while done is high, letting the caller capture it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start && !r_busy) begin
      r_acc  <= dabble({{BCD_W{1'b0}}, bin});
      r_cnt  <= CNT_W'(1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == CNT_W'(BIN_W)) begin
        r_busy <= 1'b0;
      end else begin
        r_acc <= dabble(r_acc);
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CNT_W'(BIN_W));
  assign bcd  = r_acc[BIN_W +: BCD_W];

endmodule

// File: rtl/seg7_display.sv
// rtl/seg7_display.sv - multi-digit hex/decimal seven-segment driver with blanking and blink
module seg7_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS        = 6,
  parameter int BIN_W             = 16,
  parameter int BLINK_HALF_PERIOD = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    dec_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int CNT_W = $clog2(BLINK_HALF_PERIOD) + 1;

  state_t                  r_state, w_state_nxt;
  logic [4*NUM_DIGITS-1:0] r_digits, w_digits_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_blank_lz, w_blz_nxt;
  logic                    r_pend_blz;
  logic [CNT_W-1:0]        r_blink_cnt;
  logic                    r_blink_phase;
  logic [7*NUM_DIGITS-1:0] r_seg, w_seg_nxt;
  logic                    w_start, w_busy, w_done;
  logic [4*NUM_DIGITS-1:0] w_bcd;

  assign load_ready = (r_state == IDLE);
  assign w_start    = load_valid && (r_state == IDLE) && dec_mode;
  assign seg        = r_seg;

  bin2bcd_seq #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (value[BIN_W-1:0]),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_valid_nxt  = r_valid;
    w_blz_nxt    = r_blank_lz;
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          if (dec_mode) begin
            w_state_nxt = CONVERT;
          end else begin
            w_digits_nxt = value;
            w_valid_nxt  = 1'b1;
            w_blz_nxt    = blank_lz;
          end
        end
      end
      CONVERT: begin
        if (w_done) begin
          w_digits_nxt = w_bcd;
          w_valid_nxt  = 1'b1;
          w_blz_nxt    = r_pend_blz;
          w_state_nxt  = IDLE;
        end else if (!w_busy) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Output is built from the next digit state so a hex load shows one cycle later
  always_comb begin : blank_logic
    logic v_seen;
    logic v_blank;
    v_seen    = 1'b0;
    v_blank   = 1'b0;
    w_seg_nxt = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_seen  = v_seen || (w_digits_nxt[4*i +: 4] != 4'd0) || (i == 0);
      v_blank = !w_valid_nxt || (w_blz_nxt && !v_seen) || (r_blink_phase && blink_mask[i]);
      w_seg_nxt[7*i +: 7] = v_blank ? SEG_BLANK : hex_to_seg(w_digits_nxt[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_digits   <= '0;
      r_valid    <= 1'b0;
      r_blank_lz <= 1'b0;
      r_pend_blz <= 1'b0;
      r_seg      <= '1;
    end else begin
      r_state    <= w_state_nxt;
      r_digits   <= w_digits_nxt;
      r_valid    <= w_valid_nxt;
      r_blank_lz <= w_blz_nxt;
      r_seg      <= w_seg_nxt;
      if (w_start) r_pend_blz <= blank_lz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == CNT_W'(BLINK_HALF_PERIOD - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_display.sv
// tb/tb_seg7_display.sv - self-checking bench for seg7_display
module tb_seg7_display;

  localparam int ND  = 6;
  localparam int BW  = 16;
  localparam int BHP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [23:0] value = '0;
  logic        dec_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic [41:0] seg;

  always #5 clk = ~clk;

  seg7_display #(.NUM_DIGITS(ND), .BIN_W(BW), .BLINK_HALF_PERIOD(BHP)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .value      (value),
    .dec_mode   (dec_mode),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .seg        (seg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Blink reference: phase in cycle k after reset is (k / BHP) mod 2
  int         k = 0;
  logic       used_phase = 1'b0;
  logic [5:0] used_mask = '0;
  always @(posedge clk) begin
    if (rst) begin
      k <= 0;
      used_phase <= 1'b0;
      used_mask <= '0;
    end else begin
      used_phase <= ((k / BHP) % 2) == 1;
      used_mask <= blink_mask;
      k <= k + 1;
    end
  end

  bit         m_valid = 1'b0;
  bit         m_blz = 1'b0;
  int         m_digits [ND];
  logic [6:0] seg_tbl [16];

  typedef struct {
    logic [23:0] v;
    logic        dec;
    logic        blz;
    logic [41:0] exp;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] expected();
    logic [41:0] r;
    int hi;
    bit blank;
    hi = 0;
    for (int i = 0; i < ND; i++) if (m_digits[i] != 0) hi = i;
    for (int i = 0; i < ND; i++) begin
      blank = !m_valid || (m_blz && i > hi) || (used_phase && used_mask[i]);
      r[7*i +: 7] = blank ? 7'h7F : seg_tbl[m_digits[i]];
    end
    return r;
  endfunction

  task automatic set_model(input logic [23:0] v, input logic dec, input logic blz);
    int p;
    int n;
    p = 1;
    n = int'(v[15:0]);
    for (int i = 0; i < ND; i++) begin
      m_digits[i] = dec ? (n / p) % 10 : int'((v >> (4 * i)) & 24'hF);
      p = p * 10;
    end
    m_valid = 1'b1;
    m_blz = blz;
  endtask

  task automatic do_load(input logic [23:0] v, input logic dec, input logic blz, input bit pulse);
    check("ready_before_load", {41'd0, load_ready}, 42'd1);
    value = v;
    dec_mode = dec;
    blank_lz = blz;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    value = 24'($urandom);
    dec_mode = 1'($urandom);
    blank_lz = 1'($urandom);
    if (dec) begin
      for (int i = 1; i <= BW; i++) begin
        check("convert_ready_low", {41'd0, load_ready}, 42'd0);
        check("convert_seg_hold", seg, expected());
        load_valid = pulse && (i == 3);
        if (load_valid) begin
          value = 24'h00ABCD;
          dec_mode = 1'b0;
        end
        tick();
      end
      load_valid = 1'b0;
    end
    set_model(v, dec, blz);
    check("ready_after_load", {41'd0, load_ready}, 42'd1);
    check("seg_after_load", seg, expected());
  endtask

  initial begin
    int blanks;
    logic [23:0] rv;
    logic rd;
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < ND; i++) m_digits[i] = 0;

    vecs[0] = '{24'h00A3F0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h40}};
    vecs[1] = '{24'd1234,   1'b1, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[2] = '{24'd65535,  1'b1, 1'b0, {7'h40, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
    vecs[3] = '{24'h000000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{24'h123456, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
    vecs[5] = '{24'd0,      1'b1, 1'b0, {6{7'h40}}};
    vecs[6] = '{24'hFFFFFF, 1'b0, 1'b1, {6{7'h0E}}};
    vecs[7] = '{24'h000100, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h12, 7'h02}};
    vecs[8] = '{24'hFF0007, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}};

    rst = 1'b1;
    repeat (3) tick();
    check("reset_seg", seg, {42{1'b1}});
    check("reset_ready", {41'd0, load_ready}, 42'd1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_blank", seg, {42{1'b1}});
    end

    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i].v, vecs[i].dec, vecs[i].blz, 1'b0);
      check($sformatf("vec%0d", i), seg, vecs[i].exp);
    end

    do_load(24'd65535, 1'b1, 1'b0, 1'b1);
    check("ignored_second_load", seg, {7'h40, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12});

    do_load(24'h000005, 1'b0, 1'b0, 1'b0);
    blink_mask = 6'b000001;
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("blink_seg", seg, expected());
      check("blink_other_steady", {7'd0, seg[41:7]}, {7'd0, {5{7'h40}}});
      if (seg[6:0] == 7'h7F) blanks++;
    end
    check("blink_blank_count", 42'(blanks), 42'd8);
    blink_mask = '0;
    tick();

    check("ready_before_rst_conv", {41'd0, load_ready}, 42'd1);
    value = 24'd1234;
    dec_mode = 1'b1;
    blank_lz = 1'b0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_valid = 1'b0;
    check("rst_conv_seg", seg, {42{1'b1}});
    check("rst_conv_ready", {41'd0, load_ready}, 42'd1);
    repeat (20) tick();
    check("rst_conv_no_write", seg, {42{1'b1}});
    do_load(24'h000000, 1'b0, 1'b1, 1'b0);
    check("after_rst_zero", seg, {{5{7'h7F}}, 7'h40});

    for (int i = 0; i < 40; i++) begin
      blink_mask = 6'($urandom);
      rd = 1'($urandom);
      rv = 24'($urandom) >> ($urandom % 24);
      do_load(rv, rd, 1'($urandom), ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
